// File: rtl/pro_pkg.sv
// Shared constants and types for the binary fully-connected result path.
package pro_pkg;

  localparam int PRO_PARALLEL = 8;    // neurons per PE-array group
  localparam int PRO_WIDTH    = 8;    // scaled sum / threshold width
  localparam int PRO_CH_CNT   = 128;  // output neurons of the layer
  localparam int ACC_WIDTH    = 16;   // raw accumulator width inside the PE

  typedef logic signed [PRO_PARALLEL-1:0][PRO_WIDTH-1:0] sum_vec_t;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pro_bin_packer.sv
// Sign-binarizes one group of sums against thresholds, packs the bits into
// activation words and holds each finished word behind a valid/ready handshake.
module pro_bin_packer
  import pro_pkg::*;
#(
  parameter int PAR   = PRO_PARALLEL,
  parameter int WIDTH = PRO_WIDTH,
  parameter int OUT_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cap_i,
  input  logic                            grp_last_i,
  input  logic signed [PAR-1:0][WIDTH-1:0] sum_i,
  input  logic signed [PAR-1:0][WIDTH-1:0] thr_i,
  input  logic                            out_ready_i,
  output logic [OUT_W-1:0]                out_data_o,
  output logic                            out_valid_o,
  output logic                            out_last_o,
  output logic                            last_slot_o
);

  localparam int WPG = OUT_W / PAR;
  localparam int PCW = clog2_min1(WPG);
  localparam logic [PCW-1:0] LAST_SLOT = PCW'(WPG - 1);

  logic [PCW-1:0]   pack_cnt_q, pack_cnt_d;
  logic [OUT_W-1:0] pack_buf_q, pack_buf_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [PAR-1:0]   bits;
  logic [OUT_W-1:0] word;

  // Per-neuron signed compare; a tie binarizes to 1.
  always_comb begin
    for (int i = 0; i < PAR; i++) bits[i] = ($signed(sum_i[i]) >= $signed(thr_i[i]));
  end

  // Current buffer with this group's bits dropped into their slot.
  always_comb begin
    word = pack_buf_q;
    word[pack_cnt_q*PAR +: PAR] = bits;
  end

  // Slot advance, word hand-off on the last slot, and output pop.
  always_comb begin
    pack_cnt_d  = pack_cnt_q;
    pack_buf_d  = pack_buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (cap_i) begin
      if (pack_cnt_q == LAST_SLOT) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
        out_last_d  = grp_last_i;
        pack_cnt_d  = '0;
      end else begin
        pack_buf_d = word;
        pack_cnt_d = pack_cnt_q + 1'b1;
      end
    end
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pack_cnt_q  <= '0;
      pack_buf_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      pack_cnt_q  <= pack_cnt_d;
      pack_buf_q  <= pack_buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign last_slot_o = (pack_cnt_q == LAST_SLOT);

endmodule

// File: rtl/pro_bin_collector.sv
// Result-side sequencer for the binary FC PE array: counts pixel beats,
// drives the accumulator-load strobe, and triggers capture/packing per group.
module pro_bin_collector
  import pro_pkg::*;
#(
  parameter int PAR    = PRO_PARALLEL,
  parameter int WIDTH  = PRO_WIDTH,
  parameter int IN_LEN = 784,
  parameter int GROUPS = PRO_CH_CNT / PRO_PARALLEL,
  parameter int OUT_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             pe_rst_n,
  input  logic signed [PAR-1:0][WIDTH-1:0] sum,
  input  logic signed [PAR-1:0][WIDTH-1:0] thr,
  output logic [clog2_min1(GROUPS)-1:0]    grp_idx,
  output logic [OUT_W-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             err
);

  localparam int BW = clog2_min1(IN_LEN);
  localparam int GW = clog2_min1(GROUPS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(IN_LEN - 1);
  localparam logic [GW-1:0] LAST_GRP  = GW'(GROUPS - 1);

  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          cap_q, cap_d;
  logic          err_q, err_d;
  logic          last_slot;
  logic          accept;

  // A group may only start if its capture cannot collide with a held word;
  // once running, the PE array has no stall, so the group never waits.
  assign in_ready = !((beat_cnt_q == '0) && last_slot && out_valid);
  assign pe_rst_n = (beat_cnt_q != '0);
  assign accept   = in_valid && ((beat_cnt_q != '0) || in_ready);

  // Beat counting, gap abort, capture pulse and group advance.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    grp_d      = grp_q;
    cap_d      = 1'b0;
    err_d      = err_q;
    if ((beat_cnt_q != '0) && !in_valid) begin
      // Partial accumulation is unusable; restart the same group.
      err_d      = 1'b1;
      beat_cnt_d = '0;
    end else if (accept) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = '0;
        cap_d      = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
    if (cap_q) grp_d = (grp_q == LAST_GRP) ? '0 : grp_q + 1'b1;
  end

  // Sequencer registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt_q <= '0;
      grp_q      <= '0;
      cap_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      grp_q      <= grp_d;
      cap_q      <= cap_d;
      err_q      <= err_d;
    end
  end

  assign grp_idx = grp_q;
  assign err     = err_q;

  pro_bin_packer #(
    .PAR   (PAR),
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .cap_i       (cap_q),
    .grp_last_i  (grp_q == LAST_GRP),
    .sum_i       (sum),
    .thr_i       (thr),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .last_slot_o (last_slot)
  );

endmodule

// File: tb/tb_pro_bin_collector.sv
// Directed bench for pro_bin_collector with PAR=4, IN_LEN=4, GROUPS=4, OUT_W=8.
module tb_pro_bin_collector;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            pe_rst_n;
  logic [3:0][7:0] sum;
  logic [3:0][7:0] thr;
  logic [1:0]      grp_idx;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            err;

  int checks = 0;
  int errors = 0;

  // Group vectors (index 3..0) and their expected 4-bit results.
  localparam logic [31:0] S_A = {8'd7, 8'd0, 8'hFD, 8'd5};   // thr 7,1,0,0 -> 1001
  localparam logic [31:0] T_A = {8'd7, 8'd1, 8'd0, 8'd0};
  localparam logic [31:0] S_B = {8'd10, 8'd10, 8'd10, 8'd10}; // thr 0 -> 1111
  localparam logic [31:0] T_B = 32'd0;
  localparam logic [31:0] S_C = {8'd1, 8'd2, 8'd3, 8'd4};     // thr 2 -> 0111
  localparam logic [31:0] T_C = {8'd2, 8'd2, 8'd2, 8'd2};
  localparam logic [31:0] S_D = {8'hFF, 8'h80, 8'd0, 8'd5};   // thr 0,-128,0,6 -> 0110
  localparam logic [31:0] T_D = {8'd0, 8'h80, 8'd0, 8'd6};
  localparam logic [31:0] S_E = {8'd1, 8'd0, 8'd1, 8'd0};     // thr 1 -> 1010
  localparam logic [31:0] T_E = {8'd1, 8'd1, 8'd1, 8'd1};
  localparam logic [31:0] S_F = {8'd5, 8'd5, 8'd5, 8'd5};     // thr 6,5,4,3 -> 0111
  localparam logic [31:0] T_F = {8'd6, 8'd5, 8'd4, 8'd3};

  pro_bin_collector #(
    .PAR(4), .WIDTH(8), .IN_LEN(4), .GROUPS(4), .OUT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pe_rst_n(pe_rst_n), .sum(sum), .thr(thr), .grp_idx(grp_idx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive n consecutive valid beats; the group's sum/thr are applied from
  // beat 1 so the previous group's values survive a back-to-back capture cycle.
  task automatic run_group(input logic [31:0] s, input logic [31:0] t, input int n);
    for (int b = 0; b < n; b++) begin
      in_valid = 1'b1;
      if (b == 1) begin sum = s; thr = t; end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL in_ready_beat%0d got %b want 1", b, in_ready);
      end
      checks++;
      if (pe_rst_n !== (b != 0)) begin
        errors++; $display("FAIL pe_rst_n_beat%0d got %b want %b", b, pe_rst_n, (b != 0));
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_word(input string nm, input logic [7:0] d, input logic l);
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_last !== l) begin
      errors++;
      $display("FAIL %s got v=%b d=%h l=%b want v=1 d=%h l=%b", nm, out_valid, out_data, out_last, d, l);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sum = '0; thr = '0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || grp_idx !== 2'd0 || pe_rst_n !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset got v=%b e=%b g=%0d pe=%b r=%b d=%h l=%b want 0 0 0 0 1 00 0",
               out_valid, err, grp_idx, pe_rst_n, in_ready, out_data, out_last);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_word;
    run_group(S_A, T_A, 4);
    run_group(S_B, T_B, 4);   // starts in group 0's capture cycle
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b want 0", out_valid); end
    tick();                   // capture edge of group 1
    check_word("single_word", 8'hF9, 1'b0);
    checks++;
    if (grp_idx !== 2'd2) begin errors++; $display("FAIL grp_after_word got %0d want 2", grp_idx); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    run_group(S_C, T_C, 4);
    tick();                   // capture group 2 into slot 0
    in_valid = 1'b1;          // group 3 wants to start
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (in_ready !== 1'b0 || pe_rst_n !== 1'b0) begin
        errors++; $display("FAIL blocked_start%0d got r=%b pe=%b want 0 0", k, in_ready, pe_rst_n);
      end
      tick();
    end
    check_word("held_word", 8'hF9, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();                   // pop edge
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pop_release got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    run_group(S_D, T_D, 4);
    tick();
    check_word("last_word", 8'h67, 1'b1);
    checks++;
    if (grp_idx !== 2'd0) begin errors++; $display("FAIL grp_wrap got %0d want 0", grp_idx); end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_last got %b want 0", out_valid); end
  endtask

  task automatic test_gap;
    run_group(S_E, T_E, 2);   // in_valid drops at beat 2
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_before_gap got %b want 0", err); end
    tick();
    checks++;
    if (err !== 1'b1 || grp_idx !== 2'd0 || pe_rst_n !== 1'b0) begin
      errors++; $display("FAIL gap got e=%b g=%0d pe=%b want 1 0 0", err, grp_idx, pe_rst_n);
    end
    out_ready = 1'b0;
    run_group(S_F, T_F, 4);   // lands in bits [3:0]
    run_group(S_E, T_E, 4);
    tick();
    check_word("after_gap", 8'hA7, 1'b0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid_group;
    run_group(S_C, T_C, 4);
    tick();
    run_group(S_D, T_D, 4);
    tick();
    check_word("frame0_last", 8'h67, 1'b1);
    tick();                   // popped
    run_group(S_A, T_A, 4);   // group 0
    tick();
    run_group(S_B, T_B, 3);   // group 1, beats 0..2
    in_valid = 1'b1; rst = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || grp_idx !== 2'd0 || err !== 1'b0 || pe_rst_n !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%b g=%0d e=%b pe=%b r=%b want 0 0 0 0 1",
                         out_valid, grp_idx, err, pe_rst_n, in_ready);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL no_word_after_reset got %b want 0", out_valid); end
    run_group(S_A, T_A, 4);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_slot got %b want 0", out_valid); end
    run_group(S_C, T_C, 4);
    tick();
    check_word("frame1_w0", 8'h79, 1'b0);
    run_group(S_E, T_E, 4);
    tick();
    run_group(S_D, T_D, 4);
    tick();
    check_word("frame1_w1", 8'h6A, 1'b1);
    checks++;
    if (grp_idx !== 2'd0) begin errors++; $display("FAIL frame1_grp got %0d want 0", grp_idx); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_word();
    test_backpressure();
    test_gap();
    test_reset_mid_group();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
